// File: rtl/exec_cond_reg.sv
// Execute-stage ARM condition check, NZCV register and EX/MEM pipeline register.
// Optional failed-condition counter enabled by defining EXEC_SQUASH_CNT_EN.
module exec_cond_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemtoRegE,
    input  logic             PCSrcE,
    input  logic             BranchE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [3:0]       ALUFlags,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [3:0]       WA3E,
    input  logic             StallM,
    input  logic             FlushM,
    output logic             CondExE,
    output logic             BranchTakenE,
    output logic [3:0]       FlagsE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemtoRegM,
    output logic             PCSrcM,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [3:0]       WA3M,
    output logic [31:0]      SquashCount
);

    localparam int unsigned CNT_W = 32;

    logic [3:0] flags;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_ex;
    logic [1:0] flag_write;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // Condition decode against the registered flags only.
    always_comb begin
        cond_ex = 1'b0;
        case (CondE)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign CondExE      = cond_ex;
    assign BranchTakenE = BranchE & cond_ex;
    assign flag_write   = FlagWriteE & {2{cond_ex}};
    assign FlagsE       = flags;

    // NZCV register; the stall hold keeps a stalled instruction from writing twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (!StallM) begin
            if (flag_write[1]) flags[3:2] <= ALUFlags[3:2];
            if (flag_write[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

    // EX/MEM register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset || FlushM) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            PCSrcM     <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WA3M       <= 4'd0;
        end else if (!StallM) begin
            RegWriteM  <= RegWriteE & cond_ex;
            MemWriteM  <= MemWriteE & cond_ex;
            MemtoRegM  <= MemtoRegE;
            PCSrcM     <= PCSrcE & cond_ex;
            ALUOutM    <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
        end
    end

`ifdef EXEC_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_cnt;
    logic             squash_evt;

    assign squash_evt = ~cond_ex & (RegWriteE | MemWriteE | PCSrcE | BranchE | (|FlagWriteE));

    // Saturating count of instructions whose side effects were suppressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            squash_cnt <= '0;
        end else if (!StallM && squash_evt && (squash_cnt != {CNT_W{1'b1}})) begin
            squash_cnt <= squash_cnt + CNT_W'(1);
        end
    end

    assign SquashCount = squash_cnt;
`else
    assign SquashCount = 32'd0;
`endif

endmodule

// File: tb/tb_exec_cond_reg.sv
// Self-checking bench for exec_cond_reg: architectural model plus directed vectors.
// Squash-counter expectations follow EXEC_SQUASH_CNT_EN when it is defined.
module tb_exec_cond_reg;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       CondE;
    logic [1:0]       FlagWriteE;
    logic             RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
    logic [WIDTH-1:0] ALUResultE, WriteDataE;
    logic [3:0]       ALUFlags, WA3E;
    logic             StallM, FlushM;
    logic             CondExE, BranchTakenE;
    logic [3:0]       FlagsE;
    logic             RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
    logic [WIDTH-1:0] ALUOutM, WriteDataM;
    logic [3:0]       WA3M;
    logic [31:0]      SquashCount;

    int total = 0;
    int bad   = 0;

    exec_cond_reg #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .CondE(CondE), .FlagWriteE(FlagWriteE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .BranchE(BranchE), .ALUResultE(ALUResultE),
        .ALUFlags(ALUFlags), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .StallM(StallM), .FlushM(FlushM), .CondExE(CondExE),
        .BranchTakenE(BranchTakenE), .FlagsE(FlagsE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .SquashCount(SquashCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM architectural form: even code is the base test, odd code its inverse.
    function automatic bit cond_pass(input bit [3:0] f, input bit [3:0] cc);
        bit n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? !base : base;
    endfunction

    // Model state
    bit              model_valid = 0;
    bit [3:0]        m_flags;
    bit              m_rw, m_mw, m_mtr, m_pcs;
    bit [WIDTH-1:0]  m_alu, m_wd;
    bit [3:0]        m_wa3;
    longint unsigned m_cnt;

    initial begin : model_update
        bit ce;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_flags = 0; m_rw = 0; m_mw = 0; m_mtr = 0; m_pcs = 0;
                m_alu = 0; m_wd = 0; m_wa3 = 0; m_cnt = 0;
                model_valid = 1;
            end else begin
                ce = cond_pass(m_flags, CondE);
                if (FlushM) begin
                    m_rw = 0; m_mw = 0; m_mtr = 0; m_pcs = 0;
                    m_alu = 0; m_wd = 0; m_wa3 = 0;
                end else if (!StallM) begin
                    m_rw = RegWriteE && ce; m_mw = MemWriteE && ce;
                    m_mtr = MemtoRegE; m_pcs = PCSrcE && ce;
                    m_alu = ALUResultE; m_wd = WriteDataE; m_wa3 = WA3E;
                end
                if (!StallM && ce) begin
                    if (FlagWriteE[1]) begin m_flags[3] = ALUFlags[3]; m_flags[2] = ALUFlags[2]; end
                    if (FlagWriteE[0]) begin m_flags[1] = ALUFlags[1]; m_flags[0] = ALUFlags[0]; end
                end
`ifdef EXEC_SQUASH_CNT_EN
                if (!StallM && !ce && (RegWriteE || MemWriteE || PCSrcE || BranchE || FlagWriteE != 0)
                    && m_cnt < 64'hFFFF_FFFF)
                    m_cnt++;
`endif
            end
        end
    end

    initial begin : compare
        bit ce;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                ce = cond_pass(m_flags, CondE);
                check("CondExE", 32'(CondExE), 32'(ce));
                check("BranchTakenE", 32'(BranchTakenE), 32'(BranchE && ce));
                check("FlagsE", 32'(FlagsE), 32'(m_flags));
                check("RegWriteM", 32'(RegWriteM), 32'(m_rw));
                check("MemWriteM", 32'(MemWriteM), 32'(m_mw));
                check("MemtoRegM", 32'(MemtoRegM), 32'(m_mtr));
                check("PCSrcM", 32'(PCSrcM), 32'(m_pcs));
                check("ALUOutM", ALUOutM, m_alu);
                check("WriteDataM", WriteDataM, m_wd);
                check("WA3M", 32'(WA3M), 32'(m_wa3));
                check("SquashCount", SquashCount, m_cnt[31:0]);
            end
        end
    end

    task automatic idle();
        CondE = 4'b1110; FlagWriteE = 2'b00;
        RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0; BranchE = 0;
        ALUResultE = '0; WriteDataE = '0; ALUFlags = 4'h0; WA3E = 4'h0;
        StallM = 0; FlushM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef EXEC_SQUASH_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        check("rst_flags", 32'(FlagsE), 32'h0);
        check("rst_regwrite", 32'(RegWriteM), 32'h0);
        check("rst_aluout", ALUOutM, 32'h0);
        check("rst_squash", SquashCount, 32'h0);
        reset = 0;

        // ADDS setting Z,C; then EQ passes
        idle(); FlagWriteE = 2'b11; ALUFlags = 4'b0110; RegWriteE = 1;
        ALUResultE = 32'h1234; WA3E = 4'd3;
        tick();
        check("adds_flags", 32'(FlagsE), 32'h6);
        check("adds_aluout", ALUOutM, 32'h1234);
        check("adds_regwrite", 32'(RegWriteM), 32'h1);
        idle(); CondE = 4'b0000; #1;
        check("eq_pass", 32'(CondExE), 32'h1);
        tick();

        // N=1,V=0 -> GE fails and is squashed
        idle(); FlagWriteE = 2'b11; ALUFlags = 4'b1000;
        tick();
        idle(); CondE = 4'b1010; RegWriteE = 1; MemWriteE = 1;
        FlagWriteE = 2'b11; ALUFlags = 4'b0101; #1;
        check("ge_fail", 32'(CondExE), 32'h0);
        tick();
        check("ge_regwrite", 32'(RegWriteM), 32'h0);
        check("ge_memwrite", 32'(MemWriteM), 32'h0);
        check("ge_flags", 32'(FlagsE), 32'h8);
        check("ge_squash", SquashCount, exp_cnt(1));

        // Partial N,Z update keeps C,V
        idle(); FlagWriteE = 2'b11; ALUFlags = 4'b1111;
        tick();
        idle(); FlagWriteE = 2'b10; ALUFlags = 4'b0000; ALUResultE = 32'h55;
        tick();
        check("partial_flags", 32'(FlagsE), 32'h3);

        // Three-cycle stall freezes M and flags
        idle(); FlagWriteE = 2'b11; ALUFlags = 4'b1000; RegWriteE = 1;
        ALUResultE = 32'hAAAA; StallM = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_aluout", ALUOutM, 32'h55);
            check("stall_flags", 32'(FlagsE), 32'h3);
        end
        StallM = 0;
        tick();
        check("release_flags", 32'(FlagsE), 32'h8);
        check("release_aluout", ALUOutM, 32'hAAAA);
        idle();
        tick();
        check("release_once", ALUOutM, 32'h0);

        // Flush and stall together
        idle(); RegWriteE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
        ALUResultE = 32'h99; FlushM = 1; StallM = 1;
        tick();
        check("flushstall_regwrite", 32'(RegWriteM), 32'h0);
        check("flushstall_flags", 32'(FlagsE), 32'h8);

        // Branch NE with Z=0, then never
        idle(); BranchE = 1; PCSrcE = 1; CondE = 4'b0001; #1;
        check("ne_taken", 32'(BranchTakenE), 32'h1);
        tick();
        check("ne_pcsrc", 32'(PCSrcM), 32'h1);
        CondE = 4'b1111; #1;
        check("nv_taken", 32'(BranchTakenE), 32'h0);
        tick();
        check("nv_pcsrc", 32'(PCSrcM), 32'h0);
        check("nv_squash", SquashCount, exp_cnt(2));

        // Reset arriving during a stall clears everything
        idle(); FlagWriteE = 2'b11; ALUFlags = 4'b1111; RegWriteE = 1; ALUResultE = 32'h77;
        tick();
        StallM = 1;
        tick();
        reset = 1;
        tick();
        check("rststall_flags", 32'(FlagsE), 32'h0);
        check("rststall_regwrite", 32'(RegWriteM), 32'h0);
        check("rststall_aluout", ALUOutM, 32'h0);
        check("rststall_squash", SquashCount, 32'h0);
        reset = 0; idle();
        tick();

        // Every condition code against every flag value
        for (int f = 0; f < 16; f++) begin
            idle(); FlagWriteE = 2'b11; ALUFlags = 4'(f);
            tick();
            for (int c = 0; c < 16; c++) begin
                idle(); CondE = 4'(c); RegWriteE = 1; MemWriteE = 4'(c) == 4'd3;
                ALUResultE = 32'(f * 16 + c); WriteDataE = 32'(c); WA3E = 4'(15 - c);
                MemtoRegE = c[0];
                tick();
            end
        end
        idle();
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
